// File: rtl/ad5791_cfg_sequencer.sv
// Configuration sequencer for up to four AD5791 DACs: drives per-channel config words and
// the serializer handshake (config mode / send pulse) for a 4-step init or a single user write.
module ad5791_cfg_sequencer #(
   parameter int NUM_DAC           = 4,
   parameter int SAXIS_TDATA_WIDTH = 32,
   parameter int HOLD_CYCLES       = 8,
   parameter int SEND_CYCLES       = 8,
   parameter int FRAME_WAIT_CYCLES = 160
) (
   input  logic                         a_clk,
   input  logic                         a_rst,
   input  logic                         start,
   input  logic [19:0]                  cfg_ctrl,
   input  logic [19:0]                  cfg_clearcode,
   input  logic [19:0]                  cfg_dac_init,
   input  logic                         user_wr,
   input  logic [23:0]                  user_word,
   input  logic [NUM_DAC-1:0]           user_mask,
   output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS1CFG_tdata,
   output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS2CFG_tdata,
   output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS3CFG_tdata,
   output logic [SAXIS_TDATA_WIDTH-1:0] M_AXIS4CFG_tdata,
   output logic                         M_AXIS1CFG_tvalid,
   output logic                         M_AXIS2CFG_tvalid,
   output logic                         M_AXIS3CFG_tvalid,
   output logic                         M_AXIS4CFG_tvalid,
   output logic                         configuration_mode,
   output logic                         configuration_send,
   output logic                         busy,
   output logic                         done,
   output logic [2:0]                   step
);

   localparam int CNT_MAX = (HOLD_CYCLES > SEND_CYCLES) ?
                            ((HOLD_CYCLES > FRAME_WAIT_CYCLES) ? HOLD_CYCLES : FRAME_WAIT_CYCLES) :
                            ((SEND_CYCLES > FRAME_WAIT_CYCLES) ? SEND_CYCLES : FRAME_WAIT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       step_reg, step_next;
   logic             user_reg, user_next;
   logic             done_reg, done_next;
   logic             load_entry;
   logic [23:0]      load_word;

   logic [SAXIS_TDATA_WIDTH-1:0] tdata_all [4];
   logic [3:0]                   tvalid_all;

   always_ff @(posedge a_clk or posedge a_rst) begin
      if (a_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         step_reg  <= 3'd0;
         user_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         step_reg  <= step_next;
         user_reg  <= user_next;
         done_reg  <= done_next;
      end
   end

   // load_entry marks every transition into LOAD; channel words are captured only then.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CNT_W'(1);
      step_next  = step_reg;
      user_next  = user_reg;
      done_next  = done_reg;
      load_entry = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (start) begin
               state_next = LOAD;
               step_next  = 3'd0;
               user_next  = 1'b0;
               done_next  = 1'b0;
               load_entry = 1'b1;
            end else if (user_wr) begin
               state_next = LOAD;
               step_next  = 3'd0;
               user_next  = 1'b1;
               load_entry = 1'b1;
            end
         end
         LOAD: begin
            if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
               state_next = SEND;
               cnt_next   = '0;
            end
         end
         SEND: begin
            if (cnt_reg == CNT_W'(SEND_CYCLES - 1)) begin
               state_next = WAIT;
               cnt_next   = '0;
            end
         end
         WAIT: begin
            if (cnt_reg == CNT_W'(FRAME_WAIT_CYCLES - 1)) begin
               cnt_next = '0;
               if (!user_reg && step_reg != 3'd3) begin
                  state_next = LOAD;
                  step_next  = step_reg + 3'd1;
                  load_entry = 1'b1;
               end else begin
                  state_next = IDLE;
                  if (!user_reg)
                     done_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   always_comb begin
      load_word = user_word;
      if (!user_next) begin
         case (step_next)
            3'd0:    load_word = 24'h400004;
            3'd1:    load_word = {4'h2, cfg_ctrl};
            3'd2:    load_word = {4'h3, cfg_clearcode};
            default: load_word = {4'h1, cfg_dac_init};
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         if (gi < NUM_DAC) begin : g_on
            logic [23:0] word_reg;
            logic [23:0] last_reg;
            logic        last_vld_reg;
            logic        en_reg;
            logic        chan_sel;
            logic        fresh;

            assign chan_sel = user_next ? user_mask[gi] : 1'b1;
            // A word identical to the last one delivered on this channel is withheld.
            assign fresh    = !last_vld_reg || (last_reg != load_word);

            always_ff @(posedge a_clk or posedge a_rst) begin
               if (a_rst) begin
                  word_reg     <= 24'h0;
                  last_reg     <= 24'h0;
                  last_vld_reg <= 1'b0;
                  en_reg       <= 1'b0;
               end else if (load_entry) begin
                  if (chan_sel) begin
                     word_reg     <= load_word;
                     en_reg       <= fresh;
                     last_reg     <= load_word;
                     last_vld_reg <= 1'b1;
                  end else begin
                     word_reg <= 24'h0;
                     en_reg   <= 1'b0;
                  end
               end
            end

            assign tdata_all[gi]  = SAXIS_TDATA_WIDTH'(word_reg);
            assign tvalid_all[gi] = en_reg && (state_reg == LOAD);
         end else begin : g_off
            assign tdata_all[gi]  = '0;
            assign tvalid_all[gi] = 1'b0;
         end
      end
   endgenerate

   assign M_AXIS1CFG_tdata   = tdata_all[0];
   assign M_AXIS2CFG_tdata   = tdata_all[1];
   assign M_AXIS3CFG_tdata   = tdata_all[2];
   assign M_AXIS4CFG_tdata   = tdata_all[3];
   assign M_AXIS1CFG_tvalid  = tvalid_all[0];
   assign M_AXIS2CFG_tvalid  = tvalid_all[1];
   assign M_AXIS3CFG_tvalid  = tvalid_all[2];
   assign M_AXIS4CFG_tvalid  = tvalid_all[3];

   assign busy               = (state_reg != IDLE);
   assign configuration_mode = (state_reg != IDLE);
   assign configuration_send = (state_reg == SEND);
   assign done               = done_reg;
   assign step               = step_reg;

endmodule

// File: doc/ad5791_cfg_sequencer.md
AD5791_CFG_SEQUENCER -- requirements
Module: ad5791_cfg_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_DAC, default 4, number of DAC channels; SAXIS_TDATA_WIDTH, default 32, config stream width; HOLD_CYCLES, default 8, tvalid hold length; SEND_CYCLES, default 8, configuration_send pulse length; FRAME_WAIT_CYCLES, default 160, post-send wait for the serializer frame.
REQ-002 Ports SHALL be:
- a_clk  in  1  sole clock; all logic on rising edge
- a_rst  in  1  asynchronous, active-high reset
- start  in  1  start full init sequence (level sampled per cycle)
- cfg_ctrl  in  20  AD5791 control-register data field
- cfg_clearcode  in  20  clearcode-register data field
- cfg_dac_init  in  20  initial DAC-register data field
- user_wr  in  1  single user word write request
- user_word  in  24  raw AD5791 frame (R/W, addr[2:0], data[19:0])
- user_mask  in  NUM_DAC  channels receiving user_word
- M_AXIS1CFG_tdata..M_AXIS4CFG_tdata  out  SAXIS_TDATA_WIDTH  per-DAC config word
- M_AXIS1CFG_tvalid..M_AXIS4CFG_tvalid  out  1  per-DAC valid
- configuration_mode  out  1  selects config path in DAC serializer
- configuration_send  out  1  serializer frame trigger
- busy  out  1  high in any non-IDLE state
- done  out  1  sticky init-complete flag
- step  out  3  current sequence index

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, SEND, WAIT; one-hot or binary encoding is free.
REQ-004 Full sequence words, all channels: step0 = 0x400004 (SW-control RESET); step1 = {4'h2, cfg_ctrl}; step2 = {4'h3, cfg_clearcode}; step3 = {4'h1, cfg_dac_init}.
REQ-005 cfg_* inputs SHALL be sampled when the step enters LOAD; changes mid-step SHALL have no effect on that step.
REQ-006 tdata SHALL be {zero pad, word[23:0]}, upper SAXIS_TDATA_WIDTH-24 bits zero.
REQ-007 tdata SHALL hold constant from LOAD entry until the step's WAIT ends.
REQ-008 IDLE->LOAD on start=1 (step=0, done<=0) one cycle after start is sampled; configuration_mode SHALL assert that same cycle.
REQ-009 LOAD: tvalid=1 on enabled channels for exactly HOLD_CYCLES cycles, then ->SEND.
REQ-010 SEND: tvalid=0, configuration_send=1 for exactly SEND_CYCLES cycles, then ->WAIT.
REQ-011 WAIT: outputs quiet for FRAME_WAIT_CYCLES cycles; then ->LOAD with step+1 if steps remain, else ->IDLE.
REQ-012 Per-step length SHALL be HOLD_CYCLES+SEND_CYCLES+FRAME_WAIT_CYCLES (defaults: 176; full sequence 704 cycles).
REQ-013 On IDLE return after step3: configuration_mode<=0, done<=1, same cycle; done holds until next start or reset.
REQ-014 user_wr=1 in IDLE SHALL run a single LOAD/SEND/WAIT step with user_word, tvalid only on user_mask channels.
- masked-off channels: tdata=0, tvalid=0
- done unchanged; configuration_mode returns to 0 at end
REQ-015 user_mask=0 SHALL still run the step timing with no tvalid asserted.
REQ-016 start and user_wr asserted together in IDLE: start wins, user_wr dropped.
REQ-017 start or user_wr while busy SHALL be ignored, not queued.
REQ-018 A repeated identical word is not retransmitted downstream (change detection); the block SHALL still execute full step timing.
REQ-019 Counters SHALL be wide enough for max(parameter) with no wrap inside a step.

Reset
REQ-020 a_rst=1 SHALL immediately force: state IDLE, all tdata 0, all tvalid 0, configuration_mode 0, configuration_send 0, busy 0, done 0, step 0, counters 0.
REQ-021 Reset mid-sequence SHALL abort without completing the step; no auto-restart after release.

Verification
REQ-022 Reset, start pulse at cycle 10, cfg_ctrl=0x00012 -> mode high cycle 11; step1 tdata=0x00200012; done=1 at cycle 715; mode=0 same cycle.
REQ-023 Per step: tvalid high exactly 8 cycles, configuration_send high exactly 8 cycles, 160 quiet cycles; step advances 0,1,2,3.
REQ-024 IDLE, user_wr with user_word=0x1ABCDE, user_mask=4'b0101 -> channels 1,3 tdata=0x001ABCDE tvalid 8 cycles; channels 2,4 tdata=0, tvalid=0; done unchanged.
REQ-025 start and user_wr same cycle -> full 4-step sequence, no user step; start pulse at sequence cycle 300 -> ignored, total still 704 cycles.
REQ-026 a_rst asserted during step2 SEND -> all outputs 0 asynchronously; after release, outputs stay IDLE until next start.
